// File: rtl/search_sequencer.sv
// rtl/search_sequencer.sv - settle/measure/update sequencer around an external current-reference solver
module search_sequencer #(
    parameter int BUS_WIDTH     = 10,
    parameter int TOL           = 1,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_ITER      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] q_desired,
    input  logic                 q_meas_valid,
    input  logic [BUS_WIDTH-1:0] q_meas,
    input  logic [BUS_WIDTH-1:0] i_ref_solver,
    input  logic                 solver_unstable,
    output logic                 solver_rst,
    output logic                 meas_ready,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 busy,
    output logic                 locked,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [5:0]           iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_SOLVER,
        S_SETTLE,
        S_MEASURE,
        S_UPDATE,
        S_LOCKED,
        S_FAULT
    } state_t;

    localparam int EW = BUS_WIDTH + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] TOL_V       = EW'(TOL);
    localparam logic [EW-1:0] TOL2_V      = EW'(2 * TOL);
    localparam logic [5:0]    MAX_ITER_V  = 6'(MAX_ITER);

    state_t               state;
    state_t               nxt;
    logic [CW-1:0]        settle_cnt;
    logic [BUS_WIDTH-1:0] target;
    logic [BUS_WIDTH-1:0] meas;
    logic [1:0]           nxt_code;
    logic [5:0]           nxt_iter;
    logic                 load_target;
    logic                 capture;
    logic [EW-1:0]        err_upd;
    logic [EW-1:0]        err_live;

    // One extra bit keeps the difference exact before taking its magnitude.
    function automatic logic [EW-1:0] abs_diff(input logic [BUS_WIDTH-1:0] a,
                                               input logic [BUS_WIDTH-1:0] b);
        logic signed [EW-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[EW-1] ? $unsigned(-d) : $unsigned(d);
    endfunction

    assign err_upd  = abs_diff(meas, target);
    assign err_live = abs_diff(q_meas, target);

    always_comb begin
        nxt         = state;
        nxt_code    = fault_code;
        nxt_iter    = iter_count;
        load_target = 1'b0;
        capture     = 1'b0;
        if (start || (state == S_LOCKED && q_desired != target)) begin
            nxt         = S_RST_SOLVER;
            nxt_code    = 2'd0;
            nxt_iter    = 6'd0;
            load_target = 1'b1;
        end else begin
            case (state)
                S_RST_SOLVER: nxt = S_SETTLE;
                S_SETTLE: begin
                    if (solver_unstable) begin
                        nxt      = S_FAULT;
                        nxt_code = 2'd1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        nxt = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (solver_unstable) begin
                        nxt      = S_FAULT;
                        nxt_code = 2'd1;
                    end else if (q_meas_valid) begin
                        nxt      = S_UPDATE;
                        capture  = 1'b1;
                        nxt_iter = iter_count + 6'd1;
                    end
                end
                S_UPDATE: begin
                    if (solver_unstable) begin
                        nxt      = S_FAULT;
                        nxt_code = 2'd1;
                    end else if (err_upd <= TOL_V) begin
                        nxt = S_LOCKED;
                    end else if (iter_count == MAX_ITER_V) begin
                        nxt      = S_FAULT;
                        nxt_code = 2'd2;
                    end else begin
                        nxt = S_SETTLE;
                    end
                end
                // Drift out of the hysteresis band re-measures without resetting the solver.
                S_LOCKED: begin
                    if (q_meas_valid && err_live > TOL2_V) begin
                        nxt      = S_SETTLE;
                        nxt_iter = 6'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            target     <= '0;
            meas       <= '0;
            fault_code <= 2'd0;
            iter_count <= 6'd0;
            solver_rst <= 1'b0;
            meas_ready <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            i_ref      <= '0;
        end else begin
            state      <= nxt;
            fault_code <= nxt_code;
            iter_count <= nxt_iter;
            if (load_target) target <= q_desired;
            if (capture) meas <= q_meas;
            settle_cnt <= (state == S_SETTLE && nxt == S_SETTLE) ? settle_cnt + CW'(1) : '0;
            solver_rst <= (nxt == S_RST_SOLVER);
            meas_ready <= (nxt == S_UPDATE);
            busy       <= (nxt == S_RST_SOLVER) || (nxt == S_SETTLE) ||
                          (nxt == S_MEASURE) || (nxt == S_UPDATE);
            locked     <= (nxt == S_LOCKED);
            fault      <= (nxt == S_FAULT);
            i_ref      <= (nxt == S_IDLE || nxt == S_FAULT) ? '0 : i_ref_solver;
        end
    end

endmodule
